fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the decode/register-file stage and driving the read port of the instruction `bram`. It walks a word-addressed fetch PC and issues one `bram` read per cycle. Returned words are buffered, tagged with their PC, in a small prefetch FIFO. It presents them to decode over a valid/ready handshake and supports pipeline redirects (branch/jump) and a halt request.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one bram read per cycle into a PC-tagged prefetch FIFO.
// Optional FETCH_STALL_CNT_EN adds o_stall_cycles (cycles in RUN with nothing to offer decode).
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_halt,
   input  logic                          i_redirect,
   input  logic [ADDR_WIDTH-1:0]         i_redirect_pc,
   output logic [ADDR_WIDTH-1:0]         o_mem_addr,
   output logic                          o_mem_write,
   input  logic [DATA_WIDTH-1:0]         i_mem_data,
   output logic [DATA_WIDTH-1:0]         o_instr,
   output logic [ADDR_WIDTH-1:0]         o_instr_pc,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]                   o_stall_cycles
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {RUN, HALT} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] fpc;
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [CW-1:0]         count;
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

   logic issue, push, pop;
   logic [CW-1:0] occupancy;

   // Occupancy counts the in-flight read so issue can never overrun the FIFO.
   assign occupancy = count + CW'(req_valid);
   assign issue     = (state == RUN) && !i_redirect && (occupancy < CW'(FIFO_DEPTH));
   assign push      = req_valid && !i_redirect;
   assign pop       = o_valid && i_ready && !i_redirect;

   assign o_mem_write = 1'b0;
   assign o_valid     = (count != '0);
   assign o_level     = count;
   assign o_instr     = o_valid ? fifo_data[rd_ptr] : '0;
   assign o_instr_pc  = o_valid ? fifo_pc[rd_ptr]   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (i_halt)  state_nxt = HALT;
         HALT:    if (!i_halt) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc        <= RESET_PC;
         o_mem_addr <= RESET_PC;
         req_valid  <= 1'b0;
         req_pc     <= '0;
      end else begin
         if (issue) begin
            o_mem_addr <= fpc;
            req_pc     <= fpc;
            req_valid  <= 1'b1;
            fpc        <= fpc + 1'b1;
         end else begin
            req_valid  <= 1'b0;
         end
         if (i_redirect) fpc <= i_redirect_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (i_redirect) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= i_mem_data;
         fifo_pc[wr_ptr]   <= req_pc;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_stall_cycles <= '0;
      else if ((state == RUN) && !o_valid && !i_redirect && (o_stall_cycles != 32'hFFFF_FFFF))
         o_stall_cycles <= o_stall_cycles + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed and random stimulus.
module tb_fetch_unit;
   localparam int          AW  = 32;
   localparam int          DW  = 32;
   localparam int          D   = 4;
   localparam logic [31:0] RPC = 32'h0;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_halt, i_redirect, i_ready;
   logic [AW-1:0] i_redirect_pc;
   logic [DW-1:0] i_mem_data = '0;
   logic [AW-1:0] o_mem_addr, o_instr_pc;
   logic [DW-1:0] o_instr;
   logic          o_mem_write, o_valid;
   logic [2:0]    o_level;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0]   o_stall_cycles;
`endif

   fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .i_halt(i_halt), .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc), .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write),
      .i_mem_data(i_mem_data), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
      .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level)
`ifdef FETCH_STALL_CNT_EN
      , .o_stall_cycles(o_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h1000 + a;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // bram: address registered at a posedge is read on the following negedge.
   always @(negedge clk) i_mem_data <= word(o_mem_addr);

   // Reference model: FIFO as a queue of PCs, one optional in-flight read.
   logic [31:0] mq[$];
   logic [31:0] m_fpc, m_addr, m_req_pc, m_stall;
   logic        m_req_v, m_run;
   int          n;
   logic        red, mpop, mpush, miss;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_fpc = RPC; m_addr = RPC; m_req_v = 1'b0; m_req_pc = '0; m_run = 1'b1; m_stall = '0;
      end else begin
         n     = mq.size();
         red   = i_redirect;
         mpop  = (n > 0) && i_ready && !red;
         mpush = m_req_v && !red;
         miss  = m_run && !red && ((n + int'(m_req_v)) < D);
         if (m_run && n == 0 && !red && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (red) mq.delete();
         else begin
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back(m_req_pc);
         end
         if (miss) begin
            m_addr = m_fpc; m_req_pc = m_fpc; m_req_v = 1'b1; m_fpc = m_fpc + 1;
         end else m_req_v = 1'b0;
         if (red) m_fpc = i_redirect_pc;
         m_run = !i_halt;
      end
   end

   logic [31:0] head;
   always @(negedge clk) begin
      head = (mq.size() != 0) ? mq[0] : 32'h0;
      chk("valid",     o_valid,    mq.size() != 0);
      chk("level",     o_level,    mq.size());
      chk("instr_pc",  o_instr_pc, head);
      chk("instr",     o_instr,    (mq.size() != 0) ? word(head) : 32'h0);
      chk("mem_addr",  o_mem_addr, m_addr);
      chk("mem_write", o_mem_write, 1'b0);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cycles", o_stall_cycles, m_stall);
`endif
   end

   // Records PCs actually handed to decode, for directed sequence checks.
   logic        rec = 1'b0;
   logic [31:0] popq[$];
   always @(negedge clk)
      if (rec && !rst && o_valid && i_ready && !i_redirect) popq.push_back(o_instr_pc);

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; step(); rst = 1'b0;
   endtask

   task automatic wait_level(input int lvl, output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (o_level == lvl[2:0]) found = 1'b1;
      end
   endtask

   initial begin
      bit          found;
      logic [31:0] frozen;
      rst = 1'b1; i_halt = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_addr",  o_mem_addr, RPC);

      // First fetch latency and back-to-back pops.
      step();
      chk("edge1_valid", o_valid, 1'b0);
      step();
      chk("edge2_valid", o_valid, 1'b1);
      chk("edge2_pc",    o_instr_pc, 32'h0);
      chk("edge2_instr", o_instr, 32'h1000);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_first", o_stall_cycles, 32'd2);
`endif
      popq.delete(); rec = 1'b1;
      repeat (4) step();
      rec = 1'b0;
      chk("seq_len", popq.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < popq.size(); i++) chk("seq_pc", popq[i], i);

      // Backpressure fills the FIFO and stops issue.
      pulse_reset(); i_ready = 1'b0;
      repeat (10) step();
      chk("bp_level", o_level, 3'd4);
      chk("bp_pc",    o_instr_pc, 32'h0);
      chk("bp_addr",  o_mem_addr, 32'h3);
      popq.delete(); rec = 1'b1; i_ready = 1'b1;
      repeat (10) step();
      rec = 1'b0;
      chk("bp_len", popq.size() >= 8, 1'b1);
      for (int i = 0; i < 8 && i < popq.size(); i++) chk("bp_seq_pc", popq[i], i);

      // Redirect with level 3 and a read in flight.
      pulse_reset(); i_ready = 1'b0;
      wait_level(3, found);
      chk("reach_level3", found, 1'b1);
      i_redirect = 1'b1; i_redirect_pc = 32'h20; i_ready = 1'b1;
      step();
      i_redirect = 1'b0;
      chk("redir_level", o_level, 3'd0);
      chk("redir_valid", o_valid, 1'b0);
      step();
      chk("redir_r1_valid", o_valid, 1'b0);
      step();
      chk("redir_r2_valid", o_valid, 1'b1);
      chk("redir_r2_pc",    o_instr_pc, 32'h20);
      chk("redir_r2_instr", o_instr, 32'h1020);

      // Halt: issue freezes, FIFO drains, resume at next sequential PC.
      repeat (5) step();
      i_halt = 1'b1;
      step();
      frozen = m_addr;
      repeat (5) step();
      chk("halt_addr",  o_mem_addr, frozen);
      chk("halt_level", o_level, 3'd0);
      i_halt = 1'b0; popq.delete(); rec = 1'b1;
      repeat (4) step();
      rec = 1'b0;
      chk("resume_len", popq.size() >= 1, 1'b1);
      if (popq.size() >= 1) chk("resume_pc", popq[0], frozen + 1);

      // Asynchronous reset between edges.
      pulse_reset(); i_ready = 1'b0;
      wait_level(2, found);
      chk("reach_level2", found, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk("async_valid", o_valid, 1'b0);
      chk("async_level", o_level, 3'd0);
      chk("async_addr",  o_mem_addr, RPC);
      step();
      rst = 1'b0; i_ready = 1'b1;
      step(); step();
      chk("restart_valid", o_valid, 1'b1);
      chk("restart_pc",    o_instr_pc, RPC);

      // Wrap-around of the fetch PC.
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
      step();
      i_redirect = 1'b0;
      repeat (8) step();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         i_ready       = ($urandom_range(0, 3) != 0);
         i_redirect    = ($urandom_range(0, 24) == 0);
         i_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         if ($urandom_range(0, 19) == 0) i_halt = ~i_halt;
         step();
      end
      i_halt = 1'b0; i_redirect = 1'b0; i_ready = 1'b1;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
